// File: rtl/uart_frame_scheduler.sv
// Frames telemetry and heartbeat packets onto a single byte-wide uart_tx,
// arbitrating the two requesters round-robin.
module uart_frame_scheduler #(
  parameter int unsigned HB_PERIOD = 50_000_000,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic       clk50mhz,
  input  logic       reset,
  input  logic       tlm_valid,
  input  logic [7:0] tlm_y,
  input  logic [7:0] tlm_x,
  input  logic [7:0] tlm_vy,
  input  logic [7:0] tlm_vx,
  input  logic [7:0] hb_status,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       frame_active,
  output logic       frame_done,
  output logic [1:0] frame_type,
  output logic [7:0] tlm_overrun,
  output logic [1:0] dbg_state
);

  localparam int HB_W = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_DRAIN} state_t;

  state_t    r_state, w_state_next;
  logic      r_tlm_pending, r_hb_pending, r_last_hb;
  logic [7:0] r_buf_y, r_buf_x, r_buf_vy, r_buf_vx;
  logic [7:0] r_sh_y, r_sh_x, r_sh_vy, r_sh_vx, r_sh_status;
  logic [2:0] r_idx;
  logic [7:0] r_ck;
  logic [HB_W-1:0] r_hb_cnt;
  logic      r_tx_start, r_frame_active, r_frame_done;
  logic [7:0] r_tx_data, r_overrun;
  logic [1:0] r_frame_type;

  logic      w_grant_tlm, w_grant_hb, w_issue, w_advance, w_finish;
  logic      w_hb_tc, w_is_last;
  logic [7:0] w_cur_byte;

  assign w_hb_tc   = (r_hb_cnt == HB_LAST);
  assign w_is_last = (r_idx == ((r_frame_type == 2'b01) ? 3'd6 : 3'd3));

  always_comb begin
    w_cur_byte = HDR_BYTE;
    if (r_frame_type == 2'b01) begin
      case (r_idx)
        3'd0:    w_cur_byte = HDR_BYTE;
        3'd1:    w_cur_byte = 8'h01;
        3'd2:    w_cur_byte = r_sh_y;
        3'd3:    w_cur_byte = r_sh_x;
        3'd4:    w_cur_byte = r_sh_vy;
        3'd5:    w_cur_byte = r_sh_vx;
        default: w_cur_byte = r_ck;
      endcase
    end else begin
      case (r_idx)
        3'd0:    w_cur_byte = HDR_BYTE;
        3'd1:    w_cur_byte = 8'h02;
        3'd2:    w_cur_byte = r_sh_status;
        default: w_cur_byte = r_ck;
      endcase
    end
  end

  // uart_tx handshake: tx_start is a one-cycle request issued only when
  // tx_busy is low; tx_busy rising acknowledges it and tx_busy falling
  // means the byte has left, after which the next byte may be requested.
  // Grants wait for an idle uart so the freshest telemetry is shadowed.
  always_comb begin
    w_state_next = r_state;
    w_grant_tlm  = 1'b0;
    w_grant_hb   = 1'b0;
    w_issue      = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!tx_busy) begin
          if (r_tlm_pending && r_hb_pending) begin
            w_grant_tlm = r_last_hb;
            w_grant_hb  = !r_last_hb;
          end else begin
            w_grant_tlm = r_tlm_pending;
            w_grant_hb  = r_hb_pending;
          end
          if (w_grant_tlm || w_grant_hb) w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!tx_busy) begin
          w_issue      = 1'b1;
          w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_busy) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          if (w_is_last) begin
            w_finish     = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_advance    = 1'b1;
            w_state_next = S_ISSUE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      r_tlm_pending  <= 1'b0;
      r_hb_pending   <= 1'b0;
      r_last_hb      <= 1'b1;
      r_buf_y        <= 8'd0;
      r_buf_x        <= 8'd0;
      r_buf_vy       <= 8'd0;
      r_buf_vx       <= 8'd0;
      r_sh_y         <= 8'd0;
      r_sh_x         <= 8'd0;
      r_sh_vy        <= 8'd0;
      r_sh_vx        <= 8'd0;
      r_sh_status    <= 8'd0;
      r_idx          <= 3'd0;
      r_ck           <= 8'd0;
      r_hb_cnt       <= '0;
      r_tx_start     <= 1'b0;
      r_tx_data      <= 8'd0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_type   <= 2'b00;
      r_overrun      <= 8'd0;
    end else begin
      r_tx_start   <= w_issue;
      r_frame_done <= w_finish;
      if (w_issue) begin
        r_tx_data <= w_cur_byte;
        if (r_idx != 3'd0 && !w_is_last) r_ck <= r_ck + w_cur_byte;
      end
      if (w_advance) r_idx <= r_idx + 3'd1;
      if (w_finish) begin
        r_frame_active <= 1'b0;
        r_frame_type   <= 2'b00;
      end
      if (w_grant_tlm || w_grant_hb) begin
        r_frame_active <= 1'b1;
        r_frame_type   <= w_grant_tlm ? 2'b01 : 2'b10;
        r_idx          <= 3'd0;
        r_ck           <= 8'd0;
        r_last_hb      <= w_grant_hb;
      end
      if (w_grant_tlm) begin
        r_sh_y  <= r_buf_y;
        r_sh_x  <= r_buf_x;
        r_sh_vy <= r_buf_vy;
        r_sh_vx <= r_buf_vx;
      end
      if (w_grant_hb) r_sh_status <= hb_status;
      // A pulse coinciding with a grant refills the buffer without counting as an overrun.
      if (tlm_valid) begin
        r_buf_y       <= tlm_y;
        r_buf_x       <= tlm_x;
        r_buf_vy      <= tlm_vy;
        r_buf_vx      <= tlm_vx;
        r_tlm_pending <= 1'b1;
        if (r_tlm_pending && !w_grant_tlm && r_overrun != 8'hFF)
          r_overrun <= r_overrun + 8'd1;
      end else if (w_grant_tlm) begin
        r_tlm_pending <= 1'b0;
      end
      r_hb_cnt <= w_hb_tc ? '0 : r_hb_cnt + HB_W'(1);
      if (w_hb_tc)         r_hb_pending <= 1'b1;
      else if (w_grant_hb) r_hb_pending <= 1'b0;
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign frame_active = r_frame_active;
  assign frame_done   = r_frame_done;
  assign frame_type   = r_frame_type;
  assign tlm_overrun  = r_overrun;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: two instances (slow and 100-cycle
// heartbeat) each driving a uart_tx model that stays busy 20 cycles per byte.
module tb_uart_frame_scheduler;

  logic clk50mhz = 1'b0;
  always #10 clk50mhz = ~clk50mhz;

  logic [1:0] rst, tlm_valid, force_busy;
  logic [7:0] tlm_y, tlm_x, tlm_vy, tlm_vx, hb_status;
  logic [1:0] tx_busy, tx_start, frame_active, frame_done;
  logic [7:0] tx_data [2];
  logic [1:0] frame_type [2];
  logic [7:0] tlm_overrun [2];
  logic [1:0] dbg_state [2];

  int busy_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int cyc = 0;
  logic [7:0] neg_data [2];
  logic [1:0] prev_start = 2'b00;
  logic [9:0] got_q0 [$], got_q1 [$], exp_q0 [$], exp_q1 [$];
  int hb_starts [$];
  int n_checks = 0;
  int n_errors = 0;

  uart_frame_scheduler #(.HB_PERIOD(1_000_000), .HDR_BYTE(8'hA5)) u_a (
    .clk50mhz(clk50mhz), .reset(rst[0]), .tlm_valid(tlm_valid[0]),
    .tlm_y(tlm_y), .tlm_x(tlm_x), .tlm_vy(tlm_vy), .tlm_vx(tlm_vx),
    .hb_status(hb_status), .tx_busy(tx_busy[0]), .tx_start(tx_start[0]),
    .tx_data(tx_data[0]), .frame_active(frame_active[0]), .frame_done(frame_done[0]),
    .frame_type(frame_type[0]), .tlm_overrun(tlm_overrun[0]), .dbg_state(dbg_state[0])
  );

  uart_frame_scheduler #(.HB_PERIOD(100), .HDR_BYTE(8'hA5)) u_b (
    .clk50mhz(clk50mhz), .reset(rst[1]), .tlm_valid(tlm_valid[1]),
    .tlm_y(tlm_y), .tlm_x(tlm_x), .tlm_vy(tlm_vy), .tlm_vx(tlm_vx),
    .hb_status(hb_status), .tx_busy(tx_busy[1]), .tx_start(tx_start[1]),
    .tx_data(tx_data[1]), .frame_active(frame_active[1]), .frame_done(frame_done[1]),
    .frame_type(frame_type[1]), .tlm_overrun(tlm_overrun[1]), .dbg_state(dbg_state[1])
  );

  assign tx_busy[0] = (busy_cnt[0] != 0) | force_busy[0];
  assign tx_busy[1] = (busy_cnt[1] != 0) | force_busy[1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // uart_tx model: captures the byte on tx_start, busy for 20 cycles, never reset.
  always @(posedge clk50mhz) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (frame_done[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (busy_cnt[i] != 0) begin
        busy_cnt[i] <= busy_cnt[i] - 1;
      end else if (tx_start[i]) begin
        busy_cnt[i] <= 20;
        check("tx_data_stable", {24'd0, tx_data[i]}, {24'd0, neg_data[i]});
        if (i == 0) got_q0.push_back({frame_type[0], tx_data[0]});
        else        got_q1.push_back({frame_type[1], tx_data[1]});
        if (i == 1 && tx_data[1] == 8'hA5 && frame_type[1] == 2'b10) hb_starts.push_back(cyc);
      end
    end
  end

  always @(negedge clk50mhz) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_start[i]) begin
        check("start_while_busy", {31'd0, tx_busy[i]}, 32'd0);
        check("start_width", {31'd0, prev_start[i]}, 32'd0);
        check("start_active", {31'd0, frame_active[i]}, 32'd1);
        neg_data[i] <= tx_data[i];
      end
      prev_start[i] <= tx_start[i];
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int i, input logic [9:0] v);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic exp_tlm(input int i, input logic [7:0] y, x, vy, vx);
    logic [7:0] ck;
    ck = 8'h01 + y + x + vy + vx;
    push_exp(i, {2'b01, 8'hA5}); push_exp(i, {2'b01, 8'h01});
    push_exp(i, {2'b01, y});     push_exp(i, {2'b01, x});
    push_exp(i, {2'b01, vy});    push_exp(i, {2'b01, vx});
    push_exp(i, {2'b01, ck});
  endtask

  task automatic exp_hb(input int i, input logic [7:0] s);
    logic [7:0] ck;
    ck = 8'h02 + s;
    push_exp(i, {2'b10, 8'hA5}); push_exp(i, {2'b10, 8'h02});
    push_exp(i, {2'b10, s});     push_exp(i, {2'b10, ck});
  endtask

  task automatic pulse_tlm(input int i, input logic [7:0] y, x, vy, vx);
    @(negedge clk50mhz);
    tlm_y = y; tlm_x = x; tlm_vy = vy; tlm_vx = vx;
    tlm_valid[i] = 1'b1;
    @(negedge clk50mhz);
    tlm_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int n, input int budget);
    int k = 0;
    while (done_cnt[i] < n && k < budget) begin
      @(negedge clk50mhz);
      k++;
    end
    check($sformatf("done_count_u%0d", i), done_cnt[i], n);
  endtask

  task automatic wait_bytes(input int i, input int n, input int budget);
    int k = 0;
    while (((i == 0) ? got_q0.size() : got_q1.size()) < n && k < budget) begin
      @(negedge clk50mhz);
      k++;
    end
    check($sformatf("byte_count_u%0d", i), ((i == 0) ? got_q0.size() : got_q1.size()) >= n, 1);
  endtask

  task automatic compare_frames(input int i, input string tag);
    logic [9:0] e, g;
    if (i == 0) begin
      while (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        g = (got_q0.size() > 0) ? got_q0.pop_front() : 10'h3FF;
        check(tag, {22'd0, g}, {22'd0, e});
      end
      check({tag, "_extra"}, got_q0.size(), 0);
    end else begin
      while (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        g = (got_q1.size() > 0) ? got_q1.pop_front() : 10'h3FF;
        check(tag, {22'd0, g}, {22'd0, e});
      end
      check({tag, "_extra"}, got_q1.size(), 0);
    end
  endtask

  initial begin
    logic [9:0] w, b, ck;
    logic [7:0] sum;
    int nf, n;
    rst = 2'b11; tlm_valid = 2'b00; force_busy = 2'b00;
    tlm_y = 8'd0; tlm_x = 8'd0; tlm_vy = 8'd0; tlm_vx = 8'd0; hb_status = 8'h33;
    repeat (3) @(negedge clk50mhz);
    check("rst_tx_start", tx_start[0], 0);
    check("rst_tx_data", tx_data[0], 0);
    check("rst_frame_active", frame_active[0], 0);
    check("rst_frame_done", frame_done[0], 0);
    check("rst_frame_type", frame_type[0], 0);
    check("rst_overrun", tlm_overrun[0], 0);
    check("rst_state", dbg_state[0], 0);
    rst[0] = 1'b0;
    @(negedge clk50mhz);

    // single telemetry frame and first-byte latency
    pulse_tlm(0, 8'h10, 8'h20, 8'h03, 8'h04);
    exp_tlm(0, 8'h10, 8'h20, 8'h03, 8'h04);
    check("lat_k0_start", tx_start[0], 0);
    @(negedge clk50mhz);
    check("lat_k1_start", tx_start[0], 0);
    check("lat_k1_active", frame_active[0], 1);
    check("lat_k1_type", frame_type[0], 2'b01);
    @(negedge clk50mhz);
    check("lat_k2_start", tx_start[0], 1);
    check("lat_k2_hdr", tx_data[0], 8'hA5);
    wait_done(0, 1, 400);
    compare_frames(0, "t1_byte");
    check("t1_overrun", tlm_overrun[0], 0);
    check("t1_active_end", frame_active[0], 0);
    check("t1_type_end", frame_type[0], 0);

    // overrun while uart is held busy, then shadowing of the frame in flight
    force_busy[0] = 1'b1;
    pulse_tlm(0, 8'h11, 8'h12, 8'h13, 8'h14);
    pulse_tlm(0, 8'h21, 8'h22, 8'h23, 8'h24);
    pulse_tlm(0, 8'h31, 8'h32, 8'h33, 8'h34);
    @(negedge clk50mhz);
    check("t4_overrun", tlm_overrun[0], 2);
    check("t4_held_idle", frame_active[0], 0);
    force_busy[0] = 1'b0;
    exp_tlm(0, 8'h31, 8'h32, 8'h33, 8'h34);
    exp_tlm(0, 8'h41, 8'h42, 8'h43, 8'h44);
    wait_bytes(0, 2, 200);
    pulse_tlm(0, 8'h41, 8'h42, 8'h43, 8'h44);
    wait_done(0, 3, 800);
    compare_frames(0, "t4_byte");
    check("t4_overrun_after", tlm_overrun[0], 2);

    // reset in the middle of a frame
    pulse_tlm(0, 8'h55, 8'h66, 8'h77, 8'h88);
    wait_bytes(0, 3, 200);
    rst[0] = 1'b1;
    #1;
    check("t5_rst_start", tx_start[0], 0);
    check("t5_rst_active", frame_active[0], 0);
    check("t5_rst_type", frame_type[0], 0);
    repeat (3) @(negedge clk50mhz);
    rst[0] = 1'b0;
    repeat (300) @(negedge clk50mhz);
    check("t5_no_more_bytes", got_q0.size(), 3);
    check("t5_no_done", done_cnt[0], 3);
    check("t5_idle_active", frame_active[0], 0);
    got_q0.delete();
    pulse_tlm(0, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    exp_tlm(0, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    wait_done(0, 4, 400);
    compare_frames(0, "t5_byte");

    // overrun counter saturation
    force_busy[0] = 1'b1;
    for (int j = 0; j < 258; j++) pulse_tlm(0, j[7:0], 8'h00, 8'h00, 8'h00);
    @(negedge clk50mhz);
    check("sat_overrun", tlm_overrun[0], 255);
    force_busy[0] = 1'b0;

    // tie from reset: telemetry lands on the same edge as the first heartbeat
    @(negedge clk50mhz);
    rst[1] = 1'b0;
    repeat (98) @(negedge clk50mhz);
    pulse_tlm(1, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    exp_tlm(1, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    exp_hb(1, 8'h33);
    wait_done(1, 1, 400);
    repeat (30) @(negedge clk50mhz);
    pulse_tlm(1, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
    exp_tlm(1, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
    exp_hb(1, 8'h5A);
    wait_done(1, 2, 300);
    hb_status = 8'h5A;
    wait_done(1, 4, 600);
    compare_frames(1, "t3_byte");

    // heartbeat-only traffic settles to one frame every 100 cycles
    got_q1.delete();
    hb_starts.delete();
    for (int j = 0; j < 6; j++) exp_hb(1, 8'h5A);
    wait_done(1, 10, 1000);
    compare_frames(1, "t2_byte");
    check("t2_hb_frames", hb_starts.size(), 6);
    if (hb_starts.size() >= 6)
      for (int j = 3; j < 6; j++) check("t2_period", hb_starts[j] - hb_starts[j-1], 100);

    // random mix; frames must stay well formed
    got_q1.delete();
    for (int j = 0; j < 40; j++) begin
      repeat ($urandom_range(5, 120)) @(negedge clk50mhz);
      pulse_tlm(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    repeat (200) @(negedge clk50mhz);
    rst[1] = 1'b1;
    #1;
    nf = 0;
    while (got_q1.size() >= 4) begin
      w = got_q1.pop_front();
      check("t6_hdr", {24'd0, w[7:0]}, 32'hA5);
      w = got_q1.pop_front();
      check("t6_typebyte", (w[7:0] == 8'h01) || (w[7:0] == 8'h02), 1);
      check("t6_frame_type", {30'd0, w[9:8]}, (w[7:0] == 8'h01) ? 32'd1 : 32'd2);
      n = (w[7:0] == 8'h01) ? 4 : 1;
      if (got_q1.size() < n + 1) break;
      sum = w[7:0];
      for (int k = 0; k < n; k++) begin
        b = got_q1.pop_front();
        sum = sum + b[7:0];
      end
      ck = got_q1.pop_front();
      check("t6_checksum", {24'd0, ck[7:0]}, {24'd0, sum});
      nf++;
    end
    check("t6_frames_seen", nf > 5, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
